dff_mem_arbiter: RTL and testbench
==================================

Name: dff_mem_arbiter

Overview:
Round-robin arbiter that shares the 16x8 DFF RAM between two requesters (A, B) over valid/ready request and response channels.
- Sequences the RAM's single-cycle write and registered 1-cycle read.
- Holds read data until the owning requester accepts it.
- Sits between the RAM macro and the client logic (e.g. pin-side loader, internal sequencer).
- RAM hookup: mem_re drives RAM rin; mem_we drives RAM rout_n through an inverter in top-level glue.

Parameters:
ADDR_W, 4, RAM address width (16 bytes)
DATA_W, 8, RAM data width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
a_req_valid  input  1  requester A command valid
a_req_ready  output  1  A command accepted this cycle
a_req_we  input  1  A command type: 1 = write, 0 = read
a_req_addr  input  ADDR_W  A address
a_req_wdata  input  DATA_W  A write data
a_rsp_valid  output  1  A read data valid
a_rsp_ready  input  1  A accepts read data
a_rsp_rdata  output  DATA_W  A read data
b_*  (same 8 signals as a_*)  requester B
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_we  output  1  RAM write strobe
mem_re  output  1  RAM read strobe
mem_rdata  input  DATA_W  RAM registered read data, valid the cycle after mem_re
busy  output  1  FSM not in IDLE

Behaviour:
Reset values (async, immediate):
- FSM = IDLE; owner = A; rr_ptr = A (A has priority first).
- a/b_req_ready = 0; a/b_rsp_valid = 0; rsp data register = 0.
- mem_we = mem_re = 0; mem_addr = 0; mem_wdata = 0; busy = 0.

FSM states: IDLE, RD, RSP.

IDLE:
- Grant when any req_valid is high.
  - Only one valid: grant it.
  - Both valid: grant the side rr_ptr points to.
- req_ready for the granted side only, combinational, in IDLE only.
- Write grant:
  - mem_we = 1, mem_addr/mem_wdata = granted fields, same cycle.
  - Stay in IDLE, so back-to-back writes run 1 per cycle.
  - rr_ptr flips to the non-granted side.
- Read grant:
  - mem_re = 1, mem_addr = granted addr.
  - owner <= granted side; rr_ptr flips; next state RD.
- No request: all mem strobes 0; mem_addr/mem_wdata hold their previous values.

RD:
- No grants; both req_ready = 0; mem_we = mem_re = 0.
- Capture mem_rdata into the response register; next state RSP.

RSP:
- owner's rsp_valid = 1; owner's rsp_rdata = response register. Other side's rsp_valid = 0.
- rsp_rdata outputs show the register whenever rsp_valid is high; otherwise 0.
- rsp_ready high: next state IDLE. A new grant is possible the following cycle.
- rsp_ready low: hold valid and data stable indefinitely.

Latency: read handshake at edge N -> rsp_valid high from N+2; read throughput 1 per 3 cycles when rsp_ready is tied high.

Invariants:
- mem_we and mem_re are never high together (RAM treats simultaneous strobes as a no-op).
- Never more than one outstanding read; at most one req_ready high per cycle.

Boundary cases:
- Addresses 0 and 15 are used unchanged; no wrap logic.
- Write followed immediately by a read to the same address returns the new data (RAM write lands before the read edge).
- Requests arriving during RD/RSP wait; their valid must stay high (standard valid/ready rule), and their fields must stay stable until ready.
- rst mid-RD/RSP: the pending read is dropped and no response is issued after reset.
- The non-owner's rsp_ready is ignored.

Decomposition:
- Package dff_mem_pkg:
  - ADDR_W/DATA_W defaults.
  - State encoding localparams: IDLE = 2'd0, RD = 2'd1, RSP = 2'd2.
  - Requester id constants: REQ_A = 1'b0, REQ_B = 1'b1.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: valid pair, pointer.
  - Output: one-hot grant.
  - Combinational, reusable.
- FSM, memory muxing and response register live in dff_mem_arbiter.

Test Plan:
- Reset then single A write addr 3 data 0xA5, then A read addr 3 -> a_req_ready pulses 1 cycle each; mem_we high exactly 1 cycle; a_rsp_valid 2 cycles after read handshake with rdata 0xA5; b_rsp_valid stays 0.
- A and B both read simultaneously (A addr 1 = 0x11, B addr 2 = 0x22, preloaded) -> A granted first, B granted after A rsp handshake; responses 0x11 then 0x22; rr_ptr alternates over 4 contended reads A,B,A,B.
- Back-to-back writes from B to addrs 0..15 data = addr^0xFF, A idle -> 16 consecutive cycles mem_we = 1; readback of all addrs matches; addr 15 correct.
- A read with a_rsp_ready held low 5 cycles -> a_rsp_valid and rdata stable 5 cycles; B write pending during this time is not granted until the cycle after a_rsp_ready rises.
- Assert rst during RD -> all outputs 0 immediately (async); no rsp_valid after release; next A read returns correct data.
- Randomized mixed traffic (1000 ops) against a scoreboard model -> every read matches the model; mem_we & mem_re never both 1 (assertion).

Source files
------------

// File: rtl/dff_mem_pkg.sv
// rtl/dff_mem_pkg.sv - shared widths, FSM encoding and requester ids for the DFF RAM arbiter
package dff_mem_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin picker with one-hot grant
module rr_arb2
    import dff_mem_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    // Bit 0 is requester A, bit 1 is requester B; the pointer only matters on contention.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_ptr == REQ_A) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dff_mem_arbiter.sv
// rtl/dff_mem_arbiter.sv - round-robin sharing of the 16x8 DFF RAM between requesters A and B
module dff_mem_arbiter
    import dff_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner;
    logic              r_rr_ptr;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [1:0]        w_valid;
    logic [1:0]        w_arb_grant;
    logic [1:0]        w_grant;
    logic              w_any;
    logic              w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_rsp_on;
    logic              w_rsp_ack;

    assign w_valid = {b_req_valid, a_req_valid};

    rr_arb2 u_rr_arb2 (
        .i_valid (w_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant)
    );

    // Grants only in IDLE; rst also masks them so outputs read zero while reset is held.
    assign w_grant     = (r_state == IDLE && !rst) ? w_arb_grant : 2'b00;
    assign w_any       = |w_grant;
    assign w_sel       = w_grant[1];
    assign w_sel_we    = w_sel ? b_req_we    : a_req_we;
    assign w_sel_addr  = w_sel ? b_req_addr  : a_req_addr;
    assign w_sel_wdata = w_sel ? b_req_wdata : a_req_wdata;

    assign a_req_ready = w_grant[0];
    assign b_req_ready = w_grant[1];
    assign mem_we      = w_any &  w_sel_we;
    assign mem_re      = w_any & ~w_sel_we;
    assign mem_addr    = w_any  ? w_sel_addr  : r_addr;
    assign mem_wdata   = mem_we ? w_sel_wdata : r_wdata;

    assign w_rsp_on    = (r_state == RSP);
    assign a_rsp_valid = w_rsp_on && (r_owner == REQ_A);
    assign b_rsp_valid = w_rsp_on && (r_owner == REQ_B);
    assign a_rsp_rdata = a_rsp_valid ? r_rsp_data : '0;
    assign b_rsp_rdata = b_rsp_valid ? r_rsp_data : '0;
    assign w_rsp_ack   = (r_owner == REQ_A) ? a_rsp_ready : b_rsp_ready;
    assign busy        = (r_state != IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (mem_re) w_next_state = RD;
            RD:      w_next_state = RSP;
            RSP:     if (w_rsp_ack) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= REQ_A;
            r_rr_ptr   <= REQ_A;
            r_rsp_data <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_any) begin
                r_rr_ptr <= ~w_sel;
                r_addr   <= mem_addr;
                r_wdata  <= mem_wdata;
                if (!w_sel_we) r_owner <= w_sel;
            end
            // RAM output is valid during RD, one cycle after the read strobe.
            if (r_state == RD) r_rsp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dff_mem_arbiter.sv
// tb/tb_dff_mem_arbiter.sv - self-checking bench for dff_mem_arbiter with RAM model and scoreboard
module tb_dff_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic [3:0] a_req_addr;
    logic [7:0] a_req_wdata, a_rsp_rdata;
    logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [3:0] b_req_addr;
    logic [7:0] b_req_wdata, b_rsp_rdata;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_we, mem_re, busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_we    = 0;
    bit b_rsp_seen = 0;

    logic [7:0] ram [16];
    logic [7:0] ram_q;

    dff_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
        .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
        .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DFF RAM: single-cycle write, registered read, simultaneous strobes ignored.
    assign mem_rdata = ram_q;
    always @(posedge clk) begin
        if (mem_we && !mem_re) ram[mem_addr] <= mem_wdata;
        if (mem_re && !mem_we) ram_q <= ram[mem_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Transaction-level model: memory contents, round-robin pointer, and the one outstanding read.
    initial begin
        logic [7:0] sb [16];
        bit         m_ptr, m_owner, va, vb, any, gs, we;
        int         m_age;
        logic [3:0] m_addr, ad;
        logic [7:0] m_wdata, m_data, wd;
        for (int i = 0; i < 16; i++) sb[i] = 8'h00;
        m_ptr = 0; m_owner = 0; m_age = 0; m_addr = 0; m_wdata = 0; m_data = 0;
        forever begin
            @(negedge clk);
            if (mem_we) n_we++;
            if (b_rsp_valid) b_rsp_seen = 1;
            chk("we_re_excl", 32'(mem_we & mem_re), 32'd0);
            if (rst) begin
                m_ptr = 0; m_age = 0; m_addr = 0; m_wdata = 0;
                chk("rst_ctrl", 32'({busy, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, mem_we, mem_re}), 32'd0);
                chk("rst_bus", {mem_addr, mem_wdata, a_rsp_rdata, b_rsp_rdata, 4'h0}, 32'd0);
            end else begin
                va  = (m_age == 0) && a_req_valid;
                vb  = (m_age == 0) && b_req_valid;
                any = va | vb;
                gs  = (va && vb) ? m_ptr : vb;
                we  = gs ? b_req_we : a_req_we;
                ad  = gs ? b_req_addr : a_req_addr;
                wd  = gs ? b_req_wdata : a_req_wdata;
                chk("a_req_ready", 32'(a_req_ready), 32'(any && !gs));
                chk("b_req_ready", 32'(b_req_ready), 32'(any && gs));
                chk("mem_we", 32'(mem_we), 32'(any && we));
                chk("mem_re", 32'(mem_re), 32'(any && !we));
                chk("mem_addr", 32'(mem_addr), 32'(any ? ad : m_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'((any && we) ? wd : m_wdata));
                chk("busy", 32'(busy), 32'(m_age != 0));
                chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_age == 2 && !m_owner));
                chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_age == 2 && m_owner));
                chk("a_rsp_rdata", 32'(a_rsp_rdata), 32'((m_age == 2 && !m_owner) ? m_data : 8'h00));
                chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'((m_age == 2 && m_owner) ? m_data : 8'h00));
                if (any) begin
                    m_ptr  = !gs;
                    m_addr = ad;
                    if (we) begin
                        m_wdata = wd;
                        sb[ad]  = wd;
                    end else begin
                        m_owner = gs;
                        m_data  = sb[ad];
                        m_age   = 1;
                    end
                end else if (m_age == 1) begin
                    m_age = 2;
                end else if (m_age == 2 && (m_owner ? b_rsp_ready : a_rsp_ready)) begin
                    m_age = 0;
                end
            end
        end
    end

    task automatic send(input bit side, input bit we, input logic [3:0] ad,
                        input logic [7:0] wd, output int hs);
        bit ok;
        ok = 0; hs = -1;
        if (!side) begin
            a_req_we = we; a_req_addr = ad; a_req_wdata = wd; a_req_valid = 1;
        end else begin
            b_req_we = we; b_req_addr = ad; b_req_wdata = wd; b_req_valid = 1;
        end
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if ((!side && a_req_ready) || (side && b_req_ready)) begin
                ok = 1; hs = cyc;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!side) a_req_valid = 0; else b_req_valid = 0;
    endtask

    task automatic get_rsp(input bit side, output logic [7:0] d, output int c);
        bit ok;
        ok = 0; d = 0; c = -1;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (!side && a_rsp_valid) begin ok = 1; d = a_rsp_rdata; c = cyc; end
            if (side && b_rsp_valid)  begin ok = 1; d = b_rsp_rdata; c = cyc; end
        end
        if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int         hs, rc, w0, na, nb, k, nr, first, ops;
        logic [7:0] d, ra, rb;
        logic [3:0] order;
        bit         ga, gb, acc_a, acc_b, seen, ok;

        rst = 1;
        a_req_valid = 1; a_req_we = 1; a_req_addr = 4'd6; a_req_wdata = 8'h5A; a_rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready_masked", 32'({a_req_ready, mem_we, busy}), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        a_req_valid = 0;
        rst = 0;
        @(posedge clk); #1;

        // Single write then read of the same location.
        w0 = n_we;
        send(0, 1, 4'd3, 8'hA5, hs);
        chk("t1_we_once", 32'(n_we - w0), 32'd1);
        send(0, 0, 4'd3, 8'h00, hs);
        get_rsp(0, d, rc);
        chk("t1_rdata", 32'(d), 32'hA5);
        chk("t1_latency", 32'(rc - hs), 32'd2);
        chk("t1_b_rsp_quiet", 32'(b_rsp_seen), 32'd0);

        // Contended reads: A,B,A,B with responses 0x11 / 0x22.
        send(0, 1, 4'd1, 8'h11, hs);
        send(1, 1, 4'd2, 8'h22, hs);
        a_req_we = 0; a_req_addr = 4'd1; b_req_we = 0; b_req_addr = 4'd2;
        a_req_valid = 1; b_req_valid = 1;
        na = 0; nb = 0; k = 0; nr = 0; first = 2; order = 0; ra = 0; rb = 0;
        for (int t = 0; t < 60 && nr < 4; t++) begin
            @(negedge clk);
            ga = a_req_ready; gb = b_req_ready;
            if (ga) begin if (k < 4) order[k] = 1'b0; k++; na++; end
            if (gb) begin if (k < 4) order[k] = 1'b1; k++; nb++; end
            if (a_rsp_valid) begin ra = a_rsp_rdata; nr++; if (first == 2) first = 0; end
            if (b_rsp_valid) begin rb = b_rsp_rdata; nr++; if (first == 2) first = 1; end
            @(posedge clk); #1;
            if (ga && na == 2) a_req_valid = 0;
            if (gb && nb == 2) b_req_valid = 0;
        end
        a_req_valid = 0; b_req_valid = 0;
        chk("t2_grant_order", 32'(order), 32'b1010);
        chk("t2_grant_count", 32'(k), 32'd4);
        chk("t2_first_rsp_a", 32'(first), 32'd0);
        chk("t2_rdata_a", 32'(ra), 32'h11);
        chk("t2_rdata_b", 32'(rb), 32'h22);

        // B streams 16 writes, one per cycle, then A reads them all back.
        w0 = n_we;
        b_req_we = 1; b_req_addr = 4'd0; b_req_wdata = 8'hFF; b_req_valid = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t3_stream_ready", 32'(b_req_ready), 32'd1);
            @(posedge clk); #1;
            b_req_addr  = 4'(i + 1);
            b_req_wdata = 8'(i + 1) ^ 8'hFF;
        end
        b_req_valid = 0;
        chk("t3_we_count", 32'(n_we - w0), 32'd16);
        for (int i = 0; i < 16; i++) begin
            send(0, 0, 4'(i), 8'h00, hs);
            get_rsp(0, d, rc);
            chk("t3_readback", 32'(d), 32'(8'(i) ^ 8'hFF));
        end

        // Stalled response with a B write waiting behind it.
        a_rsp_ready = 0;
        send(0, 0, 4'd5, 8'h00, hs);
        b_req_we = 1; b_req_addr = 4'd9; b_req_wdata = 8'h99; b_req_valid = 1;
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) begin
            @(negedge clk);
            ok = a_rsp_valid;
        end
        chk("t4_rsp_arrives", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            chk("t4_hold_valid", 32'(a_rsp_valid), 32'd1);
            chk("t4_hold_data", 32'(a_rsp_rdata), 32'hFA);
            chk("t4_b_blocked", 32'(b_req_ready), 32'd0);
        end
        @(posedge clk); #1;
        a_rsp_ready = 1;
        @(negedge clk);
        chk("t4_b_wait_on_ack", 32'(b_req_ready), 32'd0);
        @(negedge clk);
        chk("t4_b_grant_after", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 0;

        // Reset in the middle of a read drops it.
        send(0, 0, 4'd7, 8'h00, hs);
        chk("t5_busy_in_rd", 32'(busy), 32'd1);
        #2 rst = 1;
        #1;
        chk("t5_async_ctrl", 32'({busy, a_rsp_valid, b_rsp_valid, mem_we, mem_re, a_req_ready, b_req_ready}), 32'd0);
        chk("t5_async_bus", 32'({mem_addr, mem_wdata}), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_rsp_valid || b_rsp_valid) seen = 1;
        end
        chk("t5_no_rsp_after_rst", 32'(seen), 32'd0);
        @(posedge clk); #1;
        send(0, 0, 4'd3, 8'h00, hs);
        get_rsp(0, d, rc);
        chk("t5_read_after_rst", 32'(d), 32'hFC);

        // Mixed random traffic; the model process checks every cycle.
        ops = 0;
        for (int t = 0; t < 20000 && ops < 1000; t++) begin
            @(negedge clk);
            acc_a = a_req_valid && a_req_ready;
            acc_b = b_req_valid && b_req_ready;
            @(posedge clk); #1;
            if (acc_a) begin ops++; a_req_valid = 0; end
            if (acc_b) begin ops++; b_req_valid = 0; end
            if (!a_req_valid && $urandom_range(0, 2) != 0) begin
                a_req_valid = 1; a_req_we = 1'($urandom_range(0, 1));
                a_req_addr = 4'($urandom_range(0, 15)); a_req_wdata = 8'($urandom_range(0, 255));
            end
            if (!b_req_valid && $urandom_range(0, 2) != 0) begin
                b_req_valid = 1; b_req_we = 1'($urandom_range(0, 1));
                b_req_addr = 4'($urandom_range(0, 15)); b_req_wdata = 8'($urandom_range(0, 255));
            end
            a_rsp_ready = ($urandom_range(0, 3) != 0);
            b_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        chk("rand_ops_done", 32'(ops >= 1000), 32'd1);
        a_req_valid = 0; b_req_valid = 0; a_rsp_ready = 1; b_rsp_ready = 1;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = !busy;
        end
        chk("rand_drain", 32'(ok), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
